psum_tile_loader: RTL and testbench

//  Upstream feeder for the corelet IFIFO path: reads one PSUM tile (row vectors of col*psum_bw) from PSUM SRAM.

---
 rtl/psum_tile_loader_pkg.sv | 13 +
 rtl/psum_tile_loader_skid_buf.sv | 45 ++++
 rtl/psum_tile_loader.sv | 130 +++++++++++++
 tb/tb_psum_tile_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_tile_loader_pkg.sv
// Shared types for the PSUM tile loader: FSM state encoding and buffer depth.
// Imported by psum_tile_loader and psum_skid_buf.
package psum_tile_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/psum_tile_loader_skid_buf.sv
// psum_skid_buf: 2-entry FIFO absorbing the SRAM read latency.
// Head entry is presented combinationally; pop on an empty buffer is ignored.
module psum_skid_buf
  import psum_tile_loader_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (occ != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      case ({push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/psum_tile_loader.sv
// PSUM tile loader: streams one tile of row vectors from PSUM SRAM onto valid/ready.
// Optional PSUM_LOADER_STRIDE_EN adds a latched address stride port.
module psum_tile_loader
  import psum_tile_loader_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
`ifdef PSUM_LOADER_STRIDE_EN
  input  logic [addr_bw-1:0]     stride,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  input  logic [col*psum_bw-1:0] sram_q,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   psum_ready
);

  localparam int CW = $clog2(row + 1);
  localparam int DW = col * psum_bw;
  localparam logic [CW-1:0] ROW_C = CW'(row);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     iss_cnt;
  logic [CW-1:0]     ret_cnt;
  logic [addr_bw-1:0] addr_q;
  logic [addr_bw-1:0] stride_q;
  logic              inflight;
  logic              issue;
  logic              start_ok;
  logic              pop;
  logic              seen;
  logic [1:0]        occ;
  logic [DW-1:0]     head;

`ifdef PSUM_LOADER_STRIDE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stride_q <= '0;
    else if (start_ok) stride_q <= stride;
  end
`else
  assign stride_q = addr_bw'(1);
`endif

  assign out_valid  = (occ != 2'd0);
  assign out_data   = head;
  assign pop        = out_valid && out_ready;
  assign busy       = (state == S_READ);
  assign done       = (state == S_DONE);
  assign sram_cen   = !issue;
  assign sram_wen   = 1'b1;
  assign sram_addr  = addr_q;
  assign psum_ready = out_valid && !seen;

  // Credit: buffered + in-flight may not exceed 2 unless a slot frees now.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    start_ok = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_nx = S_READ;
        end
      end
      S_READ: begin
        issue = (iss_cnt < ROW_C) &&
                (((occ + {1'b0, inflight}) < 2'd2) || pop);
        if (ret_cnt == ROW_C &&
            (occ == 2'd0 || (occ == 2'd1 && pop)))
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
      seen     <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (start_ok) begin
        iss_cnt <= '0;
        ret_cnt <= '0;
        addr_q  <= base_addr;
        seen    <= 1'b0;
      end else begin
        if (issue) begin
          iss_cnt <= iss_cnt + CW'(1);
          addr_q  <= addr_q + stride_q;
        end
        if (inflight) ret_cnt <= ret_cnt + CW'(1);
        if (out_valid) seen <= 1'b1;
      end
    end
  end

  psum_skid_buf #(
    .W(DW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (sram_q),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

endmodule

// File: tb/tb_psum_tile_loader.sv
// Directed self-checking bench for psum_tile_loader with a behavioural PSUM SRAM.
// Define PSUM_LOADER_STRIDE_EN to also exercise the stride/wrap scenario.
`timescale 1ns/1ps
module tb_psum_tile_loader;

  localparam int AW = 11;
  localparam int DW = 128;
  localparam int ROWS = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, sram_cen, sram_wen;
  logic          out_valid, psum_ready;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] out_data;
  int            st = 1;
`ifdef PSUM_LOADER_STRIDE_EN
  logic [AW-1:0] stride = 11'd1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  psum_tile_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
`ifdef PSUM_LOADER_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_q     (sram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .psum_ready (psum_ready)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = {a, 5'(i)};
    return v;
  endfunction

  always @(posedge clk) if (sram_cen === 1'b0) sram_q <= pat(sram_addr);

  logic [AW-1:0] iss_addr [$];
  int            iss_cyc [$];
  logic [DW-1:0] xfer_data [$];
  int            xfer_cyc [$];
  int n_done, n_psr, done_cyc, psr_cyc, fv_cyc, busy_gap, hold_bad, tmo;

  // mode 0: ready=1, 1: ready=0 for 5 cycles from first valid, 2: random
  task automatic run_tile(input logic [AW-1:0] base, input int mode,
                          input int restart_cyc);
    logic          hold_pend;
    logic [DW-1:0] hold_data;
    logic          got;
    iss_addr.delete(); iss_cyc.delete();
    xfer_data.delete(); xfer_cyc.delete();
    n_done = 0; n_psr = 0; done_cyc = -1; psr_cyc = -1;
    fv_cyc = -1; busy_gap = 0; hold_bad = 0; tmo = 0;
    hold_pend = 1'b0; hold_data = '0; got = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = (cyc == 0) || (cyc == restart_cyc);
      base_addr = (cyc == 0) ? base : (base ^ 11'h555);
      if (out_valid && fv_cyc < 0) fv_cyc = cyc;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(fv_cyc >= 0 && cyc < fv_cyc + 5);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (hold_pend && (!out_valid || out_data !== hold_data))
        hold_bad++;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (sram_cen === 1'b0) begin
        iss_addr.push_back(sram_addr);
        iss_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        xfer_data.push_back(out_data);
        xfer_cyc.push_back(cyc);
      end
      if (psum_ready) begin
        n_psr++;
        psr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        got = 1'b1;
        break;
      end else if (cyc > 0 && !busy) begin
        busy_gap++;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!got) tmo = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, psum_ready, out_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, psum_ready, out_valid});
    end
    tests++;
    if ({sram_cen, sram_wen} !== 2'b11) begin
      fails++;
      $display("FAIL reset_sram_ctl: got %b want 11", {sram_cen, sram_wen});
    end
    tests++;
    if (sram_addr !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_addr_data: addr %h data %h want 0",
               sram_addr, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_full_rate();
    logic [AW-1:0] ea;
    run_tile(11'h010, 0, -1);
    tests++;
    if (tmo != 0 || iss_addr.size() != ROWS || xfer_data.size() != ROWS) begin
      fails++;
      $display("FAIL full_counts: tmo %0d iss %0d xfer %0d want 0 8 8",
               tmo, iss_addr.size(), xfer_data.size());
    end
    for (int i = 0; i < iss_addr.size() && i < ROWS; i++) begin
      ea = AW'(11'h010 + i);
      tests++;
      if (iss_addr[i] !== ea || iss_cyc[i] != i + 1) begin
        fails++;
        $display("FAIL full_issue[%0d]: addr %h cyc %0d want %h %0d",
                 i, iss_addr[i], iss_cyc[i], ea, i + 1);
      end
    end
    for (int i = 0; i < xfer_data.size() && i < ROWS; i++) begin
      ea = AW'(11'h010 + i);
      tests++;
      if (xfer_data[i] !== pat(ea) || xfer_cyc[i] != i + 3) begin
        fails++;
        $display("FAIL full_xfer[%0d]: data %h cyc %0d want %h %0d",
                 i, xfer_data[i], xfer_cyc[i], pat(ea), i + 3);
      end
    end
    tests++;
    if (done_cyc != 11 || n_done != 1) begin
      fails++;
      $display("FAIL full_done: cyc %0d cnt %0d want 11 1", done_cyc, n_done);
    end
    tests++;
    if (n_psr != 1 || psr_cyc != 3 || fv_cyc != 3 || busy_gap != 0) begin
      fails++;
      $display("FAIL full_psum_ready: n %0d cyc %0d fv %0d gap %0d want 1 3 3 0",
               n_psr, psr_cyc, fv_cyc, busy_gap);
    end
  endtask

  task automatic test_stall();
    int early;
    run_tile(11'h040, 1, -1);
    early = 0;
    foreach (iss_cyc[i]) if (iss_cyc[i] <= fv_cyc + 4) early++;
    tests++;
    if (early != 2) begin
      fails++;
      $display("FAIL stall_issues: got %0d want 2", early);
    end
    tests++;
    if (hold_bad != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d violations want 0", hold_bad);
    end
    tests++;
    if (xfer_data.size() != ROWS || n_done != 1 || tmo != 0) begin
      fails++;
      $display("FAIL stall_counts: xfer %0d done %0d tmo %0d want 8 1 0",
               xfer_data.size(), n_done, tmo);
    end
    for (int i = 0; i < xfer_data.size() && i < ROWS; i++) begin
      tests++;
      if (xfer_data[i] !== pat(AW'(11'h040 + i))) begin
        fails++;
        $display("FAIL stall_data[%0d]: got %h want %h",
                 i, xfer_data[i], pat(AW'(11'h040 + i)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] bases [3];
    int psr_total, bad, nx;
    bases[0] = 11'h100; bases[1] = 11'h108; bases[2] = 11'h3FC;
    psr_total = 0; bad = 0; nx = 0;
    for (int t = 0; t < 3; t++) begin
      run_tile(bases[t], 2, -1);
      psr_total += n_psr;
      nx += xfer_data.size();
      bad += hold_bad + tmo + (n_done != 1 ? 1 : 0);
      for (int i = 0; i < xfer_data.size() && i < ROWS; i++)
        if (xfer_data[i] !== pat(AW'(bases[t] + i))) bad++;
    end
    tests++;
    if (psr_total != 3) begin
      fails++;
      $display("FAIL b2b_psum_ready: got %0d want 3", psr_total);
    end
    tests++;
    if (nx != 3 * ROWS || bad != 0) begin
      fails++;
      $display("FAIL b2b_data: xfers %0d errors %0d want 24 0", nx, bad);
    end
  endtask

  task automatic test_start_in_read();
    int bz;
    run_tile(11'h020, 0, 5);
    tests++;
    if (n_done != 1 || busy_gap != 0 || xfer_data.size() != ROWS) begin
      fails++;
      $display("FAIL restart_tile: done %0d gap %0d xfer %0d want 1 0 8",
               n_done, busy_gap, xfer_data.size());
    end
    tests++;
    if (xfer_data.size() > 7 && xfer_data[7] !== pat(11'h027)) begin
      fails++;
      $display("FAIL restart_last: got %h want %h", xfer_data[7], pat(11'h027));
    end
    bz = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (busy || done) bz++;
    end
    tests++;
    if (bz != 0) begin
      fails++;
      $display("FAIL restart_queued: busy/done cycles %0d want 0", bz);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    base_addr = 11'h030;
    out_ready = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    tests++;
    if (!busy || !out_valid || out_data !== pat(11'h034)) begin
      fails++;
      $display("FAIL mid_pre: busy %b valid %b data %h want 1 1 %h",
               busy, out_valid, out_data, pat(11'h034));
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, done, psum_ready, out_valid, sram_cen, sram_wen} !== 6'b000011 ||
        sram_addr !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL mid_reset: flags %b addr %h data %h want 000011 0 0",
               {busy, done, psum_ready, out_valid, sram_cen, sram_wen},
               sram_addr, out_data);
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_tile(11'h200, 0, -1);
    tests++;
    if (n_done != 1 || n_psr != 1 || xfer_data.size() != ROWS || fv_cyc != 3) begin
      fails++;
      $display("FAIL mid_restart: done %0d psr %0d xfer %0d fv %0d want 1 1 8 3",
               n_done, n_psr, xfer_data.size(), fv_cyc);
    end
    tests++;
    if (xfer_data.size() > 0 && xfer_data[0] !== pat(11'h200)) begin
      fails++;
      $display("FAIL mid_first: got %h want %h", xfer_data[0], pat(11'h200));
    end
  endtask

`ifdef PSUM_LOADER_STRIDE_EN
  task automatic test_stride();
    logic [AW-1:0] want [4];
    stride = 11'd4;
    want[0] = 11'h7F8; want[1] = 11'h7FC; want[2] = 11'h000; want[3] = 11'h004;
    run_tile(11'h7F8, 0, -1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (iss_addr.size() <= i || iss_addr[i] !== want[i]) begin
        fails++;
        $display("FAIL stride_addr[%0d]: got %h want %h", i,
                 (iss_addr.size() > i) ? iss_addr[i] : 11'h0, want[i]);
      end
    end
    tests++;
    if (xfer_data.size() != ROWS || xfer_data[2] !== pat(11'h000)) begin
      fails++;
      $display("FAIL stride_data: xfer %0d want 8 with wrapped data",
               xfer_data.size());
    end
    stride = 11'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_stall();
    test_back_to_back();
    test_start_in_read();
    test_reset_mid();
`ifdef PSUM_LOADER_STRIDE_EN
    test_stride();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
